lcd_refresh_ctrl: RTL

- Sequencer sitting directly above the 4-bit HD44780 LCD transfer engine (lcd_comm).
- Once the engine finishes its power-on 4-bit entry, issues the display init command list.
- Then repeatedly refreshes a 2x16 character frame from an internal 32-byte character buffer that game logic writes through a simple write port.
- Issues exactly one byte transfer at a time through the engine's start/busy handshake.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_refresh_ctrl_if.sv | 21 ++
 rtl/lcd_char_buf.sv | 23 ++
 rtl/lcd_refresh_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared encodings and HD44780 command bytes for the LCD refresh sequencer.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_BOOT,
      S_INIT,
      S_LINE,
      S_CHAR,
      S_DRAIN,
      S_GAP
   } state_t;

   localparam logic [7:0] LCD_CMD_FUNC_4B2L = 8'h28;
   localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;
   localparam logic [7:0] LCD_CMD_ROW0      = 8'h80;
   localparam logic [7:0] LCD_CMD_ROW1      = 8'hC0;
   localparam logic [7:0] LCD_SPACE         = 8'h20;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = LCD_CMD_FUNC_4B2L;
         2'd1:    init_cmd = LCD_CMD_DISP_ON;
         2'd2:    init_cmd = LCD_CMD_CLEAR;
         default: init_cmd = LCD_CMD_ENTRY_INC;
      endcase
   endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// Character-buffer write port plus the start/busy handshake to the 4-bit LCD engine.
interface lcd_refresh_ctrl_if;
   logic       buf_we;
   logic [4:0] buf_addr;
   logic [7:0] buf_wdata;
   logic       comm_start;
   logic [7:0] comm_data_w;
   logic       comm_write;
   logic       comm_system;
   logic       comm_busy;

   modport master (
      input  buf_we, buf_addr, buf_wdata, comm_busy,
      output comm_start, comm_data_w, comm_write, comm_system
   );

   modport slave (
      output buf_we, buf_addr, buf_wdata, comm_busy,
      input  comm_start, comm_data_w, comm_write, comm_system
   );
endinterface

// File: rtl/lcd_char_buf.sv
// 32x8 character frame store: async clear to spaces, sync write, comb read.
module lcd_char_buf
   import lcd_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [4:0] raddr,
   output logic [7:0] rdata
);

   logic [31:0][7:0] mem;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)    mem <= {32{LCD_SPACE}};
      else if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Init-then-refresh sequencer above the HD44780 4-bit engine; one byte in flight at a time.
// Optional LCD_REFRESH_CTRL_DIRTY_EN: only refresh after the buffer has been written.
module lcd_refresh_ctrl
   import lcd_pkg::*;
#(
   parameter int COLS       = 16,
   parameter int GAP_CYCLES = 24000000,
   parameter int GAP_WIDTH  = 25
) (
   input  logic               CLK,
   input  logic               RST,
   lcd_refresh_ctrl_if.master bus,
   output logic               init_done,
   output logic               frame_done
);

   localparam int CW = $clog2(COLS);
   localparam logic [GAP_WIDTH:0] GAP_N   = (GAP_WIDTH+1)'(GAP_CYCLES);
   localparam logic [GAP_WIDTH:0] GAP_ONE = (GAP_WIDTH+1)'(1);

   state_t                 state, state_nxt;
   logic [1:0]             init_idx, init_idx_nxt;
   logic                   row, row_nxt;
   logic [CW-1:0]          col, col_nxt;
   logic [GAP_WIDTH-1:0]   gap_cnt, gap_nxt;
   logic                   start_nxt, sys_nxt, init_done_nxt, frame_done_nxt;
   logic [7:0]             data_nxt, rd_data;
   logic                   can_issue, gap_exp, gap_go;

   lcd_char_buf u_buf (
      .CLK   (CLK),
      .RST   (RST),
      .we    (bus.buf_we),
      .waddr (bus.buf_addr),
      .wdata (bus.buf_wdata),
      .raddr ({row, col}),
      .rdata (rd_data)
   );

   // The engine raises busy combinationally with start, but gate on start too
   // so a single request can never be issued twice.
   assign can_issue = !bus.comm_busy && !bus.comm_start;
   assign gap_exp   = ({1'b0, gap_cnt} + GAP_ONE) >= GAP_N;
   assign bus.comm_write = 1'b1;

`ifdef LCD_REFRESH_CTRL_DIRTY_EN
   logic dirty, clr_dirty;
   assign clr_dirty = can_issue && (state == S_LINE) && !row;
   assign gap_go    = gap_exp && dirty;

   // A write in the same cycle as the row-0 command wins, forcing another frame.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)             dirty <= 1'b1;
      else if (bus.buf_we)  dirty <= 1'b1;
      else if (clr_dirty)   dirty <= 1'b0;
   end
`else
   assign gap_go = gap_exp;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state           <= S_BOOT;
         init_idx        <= '0;
         row             <= 1'b0;
         col             <= '0;
         gap_cnt         <= '0;
         bus.comm_start  <= 1'b0;
         bus.comm_data_w <= 8'h00;
         bus.comm_system <= 1'b1;
         init_done       <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         state           <= state_nxt;
         init_idx        <= init_idx_nxt;
         row             <= row_nxt;
         col             <= col_nxt;
         gap_cnt         <= gap_nxt;
         bus.comm_start  <= start_nxt;
         bus.comm_data_w <= data_nxt;
         bus.comm_system <= sys_nxt;
         init_done       <= init_done_nxt;
         frame_done      <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      init_idx_nxt   = init_idx;
      row_nxt        = row;
      col_nxt        = col;
      gap_nxt        = gap_cnt;
      start_nxt      = 1'b0;
      data_nxt       = bus.comm_data_w;
      sys_nxt        = bus.comm_system;
      init_done_nxt  = init_done;
      frame_done_nxt = 1'b0;
      case (state)
         S_BOOT: if (!bus.comm_busy) begin
            state_nxt    = S_INIT;
            init_idx_nxt = '0;
         end
         S_INIT: if (can_issue) begin
            start_nxt    = 1'b1;
            data_nxt     = init_cmd(init_idx);
            sys_nxt      = 1'b1;
            init_idx_nxt = init_idx + 2'd1;
            if (init_idx == 2'd3) begin
               init_done_nxt = 1'b1;
               row_nxt       = 1'b0;
               state_nxt     = S_LINE;
            end
         end
         S_LINE: if (can_issue) begin
            start_nxt = 1'b1;
            data_nxt  = row ? LCD_CMD_ROW1 : LCD_CMD_ROW0;
            sys_nxt   = 1'b1;
            col_nxt   = '0;
            state_nxt = S_CHAR;
         end
         S_CHAR: if (can_issue) begin
            start_nxt = 1'b1;
            data_nxt  = rd_data;
            sys_nxt   = 1'b0;
            col_nxt   = col + CW'(1);
            if (col == CW'(COLS-1)) begin
               if (!row) begin
                  row_nxt   = 1'b1;
                  state_nxt = S_LINE;
               end else begin
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: if (!bus.comm_busy) begin
            frame_done_nxt = 1'b1;
            gap_nxt        = '0;
            state_nxt      = S_GAP;
         end
         S_GAP: begin
            if (gap_go) begin
               row_nxt   = 1'b0;
               state_nxt = S_LINE;
            end else if (!gap_exp) begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         default: state_nxt = S_BOOT;
      endcase
   end

endmodule
